fcp_crc_engine: RTL and testbench

- Parametrised streaming CRC generator/checker for FCP frames: width, polynomial, init, output XOR, beat width and bits-per-clock are all configurable.
- Sits between the FCP byte framer and the packet layer.
- Consumes a valid/ready data stream with a last-beat marker and produces the frame CRC.
- In check mode it also flags whether the frame, including its appended CRC, leaves a zero residue.

---
 rtl/fcp_crc_engine.sv | 164 ++++++++++++++++
 tb/tb_fcp_crc_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fcp_crc_engine.sv
// Streaming MSB-first CRC generator/checker for FCP frames.
// Each beat is folded STEP bits per clock; frame end reports crc_out and residue check.
module fcp_crc_engine #(
    parameter int                 CRC_W   = 8,
    parameter logic [CRC_W-1:0]   POLY    = CRC_W'(8'h39),
    parameter logic [CRC_W-1:0]   INIT    = '0,
    parameter logic [CRC_W-1:0]   XOR_OUT = '0,
    parameter int                 DATA_W  = 8,
    parameter int                 STEP    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              chk_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              busy,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok
);

    localparam int NCH   = DATA_W / STEP;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (DATA_W % STEP != 0) begin : g_bad_step
        $error("DATA_W must be a multiple of STEP");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   lfsr_q, lfsr_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               chk_q, chk_d;
    logic               busy_q, busy_d;
    logic               vld_q, vld_d;
    logic [CRC_W-1:0]   out_q, out_d;
    logic               ok_q, ok_d;
    logic               rdy_q, rdy_d;

    logic               accept;
    logic               fin;
    logic               fin_chk;
    logic [CRC_W-1:0]   res;

    // STEP serial LFSR updates unrolled into one combinational fold
    function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c,
                                                  input logic [STEP-1:0]  d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = STEP - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // rdy_q holds s_ready low until the first edge after reset release
    assign s_ready   = rdy_q & (state_q == IDLE) & ~clr;
    assign accept    = s_valid & s_ready;
    assign busy      = busy_q;
    assign crc_valid = vld_q;
    assign crc_out   = out_q;
    assign crc_ok    = ok_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        chk_d   = chk_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        out_d   = out_q;
        ok_d    = ok_q;
        rdy_d   = 1'b1;
        fin     = 1'b0;
        fin_chk = 1'b0;
        res     = lfsr_q;

        if (clr) begin
            state_d = IDLE;
            lfsr_d  = INIT;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        res    = crc_fold(lfsr_q, s_data[DATA_W-1 -: STEP]);
                        lfsr_d = res;
                        busy_d = 1'b1;
                        if (NCH == 1) begin
                            fin     = s_last;
                            fin_chk = chk_mode;
                        end else begin
                            sh_d    = s_data << STEP;
                            cnt_d   = CNT_W'(NCH - 1);
                            last_d  = s_last;
                            chk_d   = chk_mode;
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    res    = crc_fold(lfsr_q, sh_q[DATA_W-1 -: STEP]);
                    lfsr_d = res;
                    sh_d   = sh_q << STEP;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        fin     = last_q;
                        fin_chk = chk_q;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (fin) begin
                out_d  = res ^ XOR_OUT;
                ok_d   = fin_chk & (res == '0);
                vld_d  = 1'b1;
                lfsr_d = INIT;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= INIT;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            chk_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            out_q   <= INIT ^ XOR_OUT;
            ok_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            chk_q   <= chk_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            out_q   <= out_d;
            ok_q    <= ok_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_fcp_crc_engine.sv
// Directed bench for fcp_crc_engine: three instances with STEP = 8, 1 and 2
// sharing clock and reset; expected CRCs are hand-computed for POLY 0x39.
module tb_fcp_crc_engine;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       clr, chk, s_valid, s_last;
    logic [2:0][7:0]  s_data;
    logic [2:0]       s_ready, busy, crc_valid, crc_ok;
    logic [2:0][7:0]  crc_out;
    int               passed = 0;
    int               total = 0;

    always #5 clk = ~clk;

    fcp_crc_engine #(.STEP(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .chk_mode(chk[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
        .busy(busy[0]), .crc_valid(crc_valid[0]), .crc_out(crc_out[0]), .crc_ok(crc_ok[0]));

    fcp_crc_engine #(.STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .chk_mode(chk[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
        .busy(busy[1]), .crc_valid(crc_valid[1]), .crc_out(crc_out[1]), .crc_ok(crc_ok[1]));

    fcp_crc_engine #(.STEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]), .chk_mode(chk[2]),
        .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]), .s_last(s_last[2]),
        .busy(busy[2]), .crc_valid(crc_valid[2]), .crc_out(crc_out[2]), .crc_ok(crc_ok[2]));

    task automatic drive(input int d, input logic v, input logic [7:0] dat,
                         input logic l, input logic c);
        s_valid[d] = v;
        s_data[d]  = dat;
        s_last[d]  = l;
        chk[d]     = c;
    endtask

    task automatic test_reset();
        #12;
        total++; if (s_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", s_ready); else passed++;
        total++; if (busy !== 3'b000 || crc_valid !== 3'b000 || crc_ok !== 3'b000)
            $display("FAIL rst_flags: got busy=%b vld=%b ok=%b want 0", busy, crc_valid, crc_ok); else passed++;
        total++; if (crc_out !== 24'h0) $display("FAIL rst_crc_out: got %h want 000000", crc_out); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_ready !== 3'b111) $display("FAIL rst_release_ready: got %b want 111", s_ready); else passed++;
    endtask

    task automatic test_single();
        drive(0, 1'b1, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b1) $display("FAIL single01_vld: got %b want 1", crc_valid[0]); else passed++;
        total++; if (crc_out[0] !== 8'h39) $display("FAIL single01_crc: got %h want 39", crc_out[0]); else passed++;
        total++; if (crc_ok[0] !== 1'b0) $display("FAIL single01_ok: got %b want 0", crc_ok[0]); else passed++;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b0) $display("FAIL single01_pulse: got %b want 0", crc_valid[0]); else passed++;
        total++; if (crc_out[0] !== 8'h39) $display("FAIL single01_hold: got %h want 39", crc_out[0]); else passed++;
        drive(0, 1'b1, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (crc_valid[0] !== 1'b1 || crc_out[0] !== 8'h4E)
            $display("FAIL single80_crc: got vld=%b crc=%h want 1/4e", crc_valid[0], crc_out[0]); else passed++;
        @(negedge clk);
    endtask

    task automatic test_two_beat();
        logic [7:0] b2 [3];
        logic [7:0] exp_crc [3];
        logic       exp_ok [3];
        logic       cm [3];
        b2[0] = 8'h00; exp_crc[0] = 8'h9C; exp_ok[0] = 1'b0; cm[0] = 1'b0;
        b2[1] = 8'h39; exp_crc[1] = 8'h00; exp_ok[1] = 1'b1; cm[1] = 1'b1;
        b2[2] = 8'h38; exp_crc[2] = 8'h39; exp_ok[2] = 1'b0; cm[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 8'h01, 1'b0, cm[k]);
            @(negedge clk);
            total++; if (busy[0] !== 1'b1 || crc_valid[0] !== 1'b0)
                $display("FAIL two_beat_mid[%0d]: got busy=%b vld=%b want 1/0", k, busy[0], crc_valid[0]); else passed++;
            drive(0, 1'b1, b2[k], 1'b1, cm[k]);
            @(negedge clk);
            drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
            total++; if (crc_valid[0] !== 1'b1 || crc_out[0] !== exp_crc[k] || crc_ok[0] !== exp_ok[k])
                $display("FAIL two_beat_end[%0d]: got vld=%b crc=%h ok=%b want 1/%h/%b",
                         k, crc_valid[0], crc_out[0], crc_ok[0], exp_crc[k], exp_ok[k]); else passed++;
            total++; if (busy[0] !== 1'b0) $display("FAIL two_beat_busy[%0d]: got %b want 0", k, busy[0]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_step1();
        drive(1, 1'b1, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        // a competing beat stays offered through the whole SHIFT window
        drive(1, 1'b1, 8'h01, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            total++; if (s_ready[1] !== 1'b0 || crc_valid[1] !== 1'b0)
                $display("FAIL step1_shift[%0d]: got rdy=%b vld=%b want 0/0", i, s_ready[1], crc_valid[1]); else passed++;
            @(negedge clk);
        end
        total++; if (crc_valid[1] !== 1'b1 || crc_out[1] !== 8'h4E)
            $display("FAIL step1_end: got vld=%b crc=%h want 1/4e", crc_valid[1], crc_out[1]); else passed++;
        total++; if (s_ready[1] !== 1'b1) $display("FAIL step1_ready: got %b want 1", s_ready[1]); else passed++;
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (busy[1] !== 1'b0 || crc_valid[1] !== 1'b0 || crc_out[1] !== 8'h4E)
            $display("FAIL step1_not_consumed: got busy=%b vld=%b crc=%h want 0/0/4e", busy[1], crc_valid[1], crc_out[1]); else passed++;
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b1 || crc_out[0] !== 8'h39)
            $display("FAIL b2b_first: got vld=%b crc=%h want 1/39", crc_valid[0], crc_out[0]); else passed++;
        drive(0, 1'b1, 8'h02, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b1 || crc_out[0] !== 8'h72)
            $display("FAIL b2b_second: got vld=%b crc=%h want 1/72", crc_valid[0], crc_out[0]); else passed++;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", crc_valid[0]); else passed++;
    endtask

    task automatic test_clr();
        drive(0, 1'b1, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 8'h55, 1'b1, 1'b0);
        clr[0] = 1'b1;
        #1;
        total++; if (s_ready[0] !== 1'b0) $display("FAIL clr_ready: got %b want 0", s_ready[0]); else passed++;
        @(negedge clk);
        total++; if (crc_valid[0] !== 1'b0 || busy[0] !== 1'b0 || crc_out[0] !== 8'h72 || crc_ok[0] !== 1'b0)
            $display("FAIL clr_state: got vld=%b busy=%b crc=%h ok=%b want 0/0/72/0",
                     crc_valid[0], busy[0], crc_out[0], crc_ok[0]); else passed++;
        clr[0] = 1'b0;
        drive(0, 1'b1, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (crc_valid[0] !== 1'b1 || crc_out[0] !== 8'h4E)
            $display("FAIL clr_next_frame: got vld=%b crc=%h want 1/4e", crc_valid[0], crc_out[0]); else passed++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n;
        drive(2, 1'b1, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (s_ready[2] !== 1'b0 || busy[2] !== 1'b1)
            $display("FAIL areset_shift: got rdy=%b busy=%b want 0/1", s_ready[2], busy[2]); else passed++;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (s_ready[2] !== 1'b0 || busy[2] !== 1'b0 || crc_valid[2] !== 1'b0 || crc_ok[2] !== 1'b0)
            $display("FAIL areset_flags: got rdy=%b busy=%b vld=%b ok=%b want 0", s_ready[2], busy[2], crc_valid[2], crc_ok[2]); else passed++;
        total++; if (crc_out !== 24'h0) $display("FAIL areset_crc_out: got %h want 000000", crc_out); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_ready[2] !== 1'b1) $display("FAIL areset_release_ready: got %b want 1", s_ready[2]); else passed++;
        drive(2, 1'b1, 8'h01, 1'b1, 1'b0);
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(negedge clk);
            if (i == 1) drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
            if (crc_valid[2] === 1'b1) n = i;
        end
        total++; if (n != 4) $display("FAIL areset_latency: got %0d edges want 4 (0 = timeout)", n); else passed++;
        total++; if (crc_out[2] !== 8'h39) $display("FAIL areset_next_frame: got %h want 39", crc_out[2]); else passed++;
    endtask

    initial begin
        clr = '0; chk = '0; s_valid = '0; s_last = '0; s_data = '0;
        test_reset();
        test_single();
        test_two_beat();
        test_step1();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
